alu_sequencer: RTL and testbench

Instruction fetch/decode/sequencing unit that drives the 32-bit ALU from the opposite side of its interface. Fetches 32-bit instruction words from instruction memory over a req/ack handshake, decodes opcode and register fields, presents operands and opcode to the ALU, and commits the ALU result, flag output or branch target. Owns the PC, an 8×32 register file and a 4-entry flag file.

---
 rtl/alu_seq_pkg.sv | 73 +++++++
 rtl/alu_seq_regfile.sv | 42 ++++
 rtl/alu_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants, instruction layout and FSM types for the ALU sequencer.
// Build option ALU_SEQ_ILLEGAL_TRAP_EN selects trap-vs-NOP for illegal opcodes.
package alu_seq_pkg;

    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 8;
    localparam int NUM_FLAGS = 4;
    localparam int REG_AW    = 3;
    localparam int FLAG_AW   = 2;
    localparam int OP_W      = 7;
    localparam int IMM_W     = 16;

    localparam int OP_LSB  = 0;
    localparam int RD_LSB  = 7;
    localparam int RA_LSB  = 10;
    localparam int RB_LSB  = 13;
    localparam int IMM_LSB = 16;

    localparam logic [OP_W-1:0] OP_ADD  = 7'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 7'd1;
    localparam logic [OP_W-1:0] OP_AND  = 7'd2;
    localparam logic [OP_W-1:0] OP_OR   = 7'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 7'd4;
    localparam logic [OP_W-1:0] OP_SHL  = 7'd5;
    localparam logic [OP_W-1:0] OP_LDHI = 7'd6;
    localparam logic [OP_W-1:0] OP_MOV  = 7'd7;
    localparam logic [OP_W-1:0] OP_FEQ  = 7'd8;
    localparam logic [OP_W-1:0] OP_FLT  = 7'd9;
    localparam logic [OP_W-1:0] OP_FGT  = 7'd10;
    localparam logic [OP_W-1:0] OP_FZ   = 7'd11;
    localparam logic [OP_W-1:0] OP_FAND = 7'd12;
    localparam logic [OP_W-1:0] OP_FOR  = 7'd13;
    localparam logic [OP_W-1:0] OP_JMP  = 7'd14;
    localparam logic [OP_W-1:0] OP_JMPC = 7'd15;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        CL_REG,
        CL_FLAG,
        CL_BRANCH,
        CL_ILLEGAL
    } op_class_e;

    typedef struct packed {
        logic [OP_W-1:0]  instr;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [XLEN-1:0]  reg8;
        logic [IMM_W-1:0] value;
        logic             highlow;
        logic             f1;
        logic             f2;
    } alu_ports_t;

    function automatic op_class_e op_class(input logic [OP_W-1:0] op);
        op_class_e cls;
        unique case (1'b1)
            (op <= OP_MOV):                     cls = CL_REG;
            (op >= OP_FEQ && op <= OP_FOR):     cls = CL_FLAG;
            (op == OP_JMP || op == OP_JMPC):    cls = CL_BRANCH;
            default:                            cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 8x32 register file: two read ports, one write port, plus a fixed R7 tap
// that feeds the ALU jump-target operand.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [XLEN-1:0]   rdata_a,
    output logic [XLEN-1:0]   rdata_b,
    output logic [XLEN-1:0]   rdata_r7
);

    logic [XLEN-1:0] mem_q [NUM_REGS];
    logic [XLEN-1:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a  = mem_q[raddr_a];
    assign rdata_b  = mem_q[raddr_b];
    assign rdata_r7 = mem_q[NUM_REGS-1];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/sequencing unit driving a 32-bit ALU: FETCH-DECODE-EXEC-WB.
// Define ALU_SEQ_ILLEGAL_TRAP_EN to halt on opcodes above 15 (else NOP).
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic [OP_W-1:0]   alu_instr,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [XLEN-1:0]   alu_reg8,
    output logic [IMM_W-1:0]  alu_value,
    output logic              alu_highlow,
    output logic              alu_f1,
    output logic              alu_f2,
    input  logic [XLEN-1:0]   alu_c,
    input  logic              alu_f3,
    input  logic              alu_addrch,
    input  logic [XLEN-1:0]   alu_naddr,
    output logic              retire,
    output logic              halted
);

    state_e                 state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [XLEN-1:0]        ir_q, ir_d;
    logic [NUM_FLAGS-1:0]   fl_q, fl_d;
    alu_ports_t             ports_q, ports_d;

    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd, ra, rb;
    logic [IMM_W-1:0]  imm;
    op_class_e         cls;
    logic              trap;
    logic              rf_we;
    logic [XLEN-1:0]   rf_a, rf_b, rf_r7;

    assign op  = ir_q[OP_LSB +: OP_W];
    assign rd  = ir_q[RD_LSB +: REG_AW];
    assign ra  = ir_q[RA_LSB +: REG_AW];
    assign rb  = ir_q[RB_LSB +: REG_AW];
    assign imm = ir_q[IMM_LSB +: IMM_W];
    assign cls = op_class(op);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    assign trap = (cls == CL_ILLEGAL);
`else
    assign trap = 1'b0;
`endif

    alu_seq_regfile u_regfile (
        .clock    (clock),
        .reset_n  (reset_n),
        .we       (rf_we),
        .waddr    (rd),
        .wdata    (alu_c),
        .raddr_a  (ra),
        .raddr_b  (rb),
        .rdata_a  (rf_a),
        .rdata_b  (rf_b),
        .rdata_r7 (rf_r7)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            fl_q    <= '0;
            ports_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            fl_q    <= fl_d;
            ports_q <= ports_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = trap ? S_HALT : S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // ALU ports load only on DECODE->EXEC and then hold through WB.
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        fl_d    = fl_q;
        ports_d = ports_q;
        rf_we   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (imem_ack) ir_d = imem_rdata;
            end
            S_DECODE: begin
                if (!trap) begin
                    ports_d.instr   = op;
                    ports_d.a       = rf_a;
                    ports_d.b       = rf_b;
                    ports_d.reg8    = rf_r7;
                    ports_d.value   = imm;
                    ports_d.highlow = (op == OP_LDHI);
                    ports_d.f1      = fl_q[ra[FLAG_AW-1:0]];
                    ports_d.f2      = fl_q[rb[FLAG_AW-1:0]];
                end
            end
            S_WB: begin
                pc_d = pc_q + 32'd1;
                unique case (cls)
                    CL_REG:    rf_we = 1'b1;
                    CL_FLAG:   fl_d[rd[FLAG_AW-1:0]] = alu_f3;
                    CL_BRANCH: if (alu_addrch) pc_d = alu_naddr;
                    default:   ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = '0;
        alu_instr   = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_reg8    = '0;
        alu_value   = '0;
        alu_highlow = 1'b0;
        alu_f1      = 1'b0;
        alu_f2      = 1'b0;
        retire      = 1'b0;
        halted      = 1'b0;
        if (reset_n) begin
            imem_req    = (state_q == S_FETCH);
            imem_addr   = pc_q;
            alu_instr   = ports_q.instr;
            alu_a       = ports_q.a;
            alu_b       = ports_q.b;
            alu_reg8    = ports_q.reg8;
            alu_value   = ports_q.value;
            alu_highlow = ports_q.highlow;
            alu_f1      = ports_q.f1;
            alu_f2      = ports_q.f2;
            retire      = (state_q == S_WB);
            halted      = (state_q == S_HALT);
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed + random bench for alu_sequencer with a behavioural ALU and
// an architectural reference model (registers, flags, PC).
module tb_alu_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [6:0]  alu_instr;
    logic [31:0] alu_a, alu_b, alu_reg8;
    logic [15:0] alu_value;
    logic        alu_highlow, alu_f1, alu_f2;
    logic [31:0] alu_c;
    logic        alu_f3, alu_addrch;
    logic [31:0] alu_naddr;
    logic        retire, halted;

    int total = 0;
    int bad = 0;

    logic [31:0] m_r [8];
    logic        m_fl [4];
    logic [31:0] m_pc;
    logic [31:0] last_a;

    always #5 clock = ~clock;

    alu_sequencer #(.RESET_PC(32'h0)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .alu_instr   (alu_instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_reg8    (alu_reg8),
        .alu_value   (alu_value),
        .alu_highlow (alu_highlow),
        .alu_f1      (alu_f1),
        .alu_f2      (alu_f2),
        .alu_c       (alu_c),
        .alu_f3      (alu_f3),
        .alu_addrch  (alu_addrch),
        .alu_naddr   (alu_naddr),
        .retire      (retire),
        .halted      (halted)
    );

    function automatic logic [31:0] alu_fn(input logic [6:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [15:0] v);
        case (op)
            7'd0:    return a + b;
            7'd1:    return a - b;
            7'd2:    return a & b;
            7'd3:    return a | b;
            7'd4:    return a ^ b;
            7'd5:    return a << b[4:0];
            7'd6:    return {v, a[15:0]};
            7'd7:    return {16'h0, v};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic flag_fn(input logic [6:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic f1, input logic f2);
        case (op)
            7'd8:    return a == b;
            7'd9:    return a < b;
            7'd10:   return a > b;
            7'd11:   return a == 32'd0;
            7'd12:   return f1 & f2;
            7'd13:   return f1 | f2;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        alu_c      = alu_fn(alu_instr, alu_a, alu_b, alu_value);
        alu_f3     = flag_fn(alu_instr, alu_a, alu_b, alu_f1, alu_f2);
        alu_addrch = (alu_instr == 7'd14) || (alu_instr == 7'd15 && alu_f1);
        alu_naddr  = alu_reg8;
    end

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb,
                                       input logic [15:0] imm);
        return {imm, rb, ra, rd, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        for (int i = 0; i < 4; i++) m_fl[i] = 1'b0;
        m_pc = '0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        imem_ack = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic do_instr(input logic [31:0] w, input int nwait);
        logic [6:0]  op;
        logic [2:0]  rd, ra, rb;
        logic [15:0] imm;
        int n;
        int cyc;
        op  = w[6:0];
        rd  = w[9:7];
        ra  = w[12:10];
        rb  = w[15:13];
        imm = w[31:16];
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("req_seen", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < nwait; i++) begin
            @(negedge clock);
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, m_pc);
        end
        imem_ack = 1'b1;
        imem_rdata = w;
        @(negedge clock);
        imem_rdata = $urandom;
        cyc = nwait + 2;
        chk("req_drop", 32'(imem_req), 32'd0);
        n = 0;
        while (retire !== 1'b1 && halted !== 1'b1 && n < 10) begin
            imem_ack = 1'($urandom_range(0, 1));
            @(negedge clock);
            cyc++;
            n++;
        end
        imem_ack = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        if (op > 7'd15) begin
            chk("halt_set", 32'(halted), 32'd1);
            chk("halt_noret", 32'(retire), 32'd0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                chk("halt_req", 32'(imem_req), 32'd0);
                chk("halt_ret", 32'(retire), 32'd0);
                chk("halt_stay", 32'(halted), 32'd1);
            end
            return;
        end
`endif
        chk("cycles", 32'(cyc), 32'(nwait + 4));
        chk("retire", 32'(retire), 32'd1);
        chk("alu_instr", 32'(alu_instr), 32'(op));
        chk("alu_a", alu_a, m_r[ra]);
        chk("alu_b", alu_b, m_r[rb]);
        chk("alu_reg8", alu_reg8, m_r[7]);
        chk("alu_value", 32'(alu_value), 32'(imm));
        chk("alu_highlow", 32'(alu_highlow), 32'(op == 7'd6));
        chk("alu_f1", 32'(alu_f1), 32'(m_fl[ra[1:0]]));
        chk("alu_f2", 32'(alu_f2), 32'(m_fl[rb[1:0]]));
        last_a = alu_a;
        if (op < 7'd8)
            m_r[rd] = alu_fn(op, m_r[ra], m_r[rb], imm);
        else if (op < 7'd14)
            m_fl[rd[1:0]] = flag_fn(op, m_r[ra], m_r[rb], m_fl[ra[1:0]], m_fl[rb[1:0]]);
        if (op == 7'd14 || (op == 7'd15 && m_fl[ra[1:0]]))
            m_pc = m_r[7];
        else
            m_pc = m_pc + 32'd1;
        @(negedge clock);
        chk("retire_once", 32'(retire), 32'd0);
        chk("next_req", 32'(imem_req), 32'd1);
        chk("next_addr", imem_addr, m_pc);
    endtask

    initial begin
        model_reset();
        last_a = '0;
        reset_n = 1'b0;
        @(negedge clock);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("post_rst_req", 32'(imem_req), 32'd1);

        do_instr(mk(7'd7, 3'd1, 3'd0, 3'd0, 16'd5), 0);
        do_instr(mk(7'd7, 3'd2, 3'd0, 3'd0, 16'd7), 0);
        do_instr(mk(7'd0, 3'd3, 3'd1, 3'd2, 16'd0), 0);
        do_instr(mk(7'd1, 3'd4, 3'd3, 3'd0, 16'd0), 0);
        chk("add_r3", last_a, 32'd12);

        do_instr(mk(7'd7, 3'd7, 3'd0, 3'd0, 16'h40), 0);
        do_instr(mk(7'd14, 3'd0, 3'd0, 3'd0, 16'd0), 0);
        chk("jmp_taken", imem_addr, 32'h40);
        do_instr(mk(7'd15, 3'd0, 3'd0, 3'd0, 16'd0), 0);
        chk("jmpc_fall", imem_addr, 32'h41);

        do_instr(mk(7'd7, 3'd4, 3'd0, 3'd0, 16'hFFFF), 0);
        do_instr(mk(7'd6, 3'd7, 3'd4, 3'd0, 16'hFFFF), 0);
        do_instr(mk(7'd14, 3'd0, 3'd0, 3'd0, 16'd0), 0);
        chk("jmp_top", imem_addr, 32'hFFFF_FFFF);
        do_instr(mk(7'd0, 3'd5, 3'd1, 3'd2, 16'd0), 0);
        chk("pc_wrap", imem_addr, 32'd0);

        do_instr(mk(7'd2, 3'd6, 3'd1, 3'd2, 16'd0), 3);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        do_instr(mk(7'h20, 3'd1, 3'd0, 3'd0, 16'd0), 0);
        apply_reset();
        chk("halt_clear", 32'(halted), 32'd0);
`else
        do_instr(mk(7'h20, 3'd1, 3'd0, 3'd0, 16'd0), 0);
        do_instr(mk(7'd0, 3'd0, 3'd1, 3'd1, 16'd0), 0);
        chk("illegal_nowrite", last_a, 32'd5);
`endif

        for (int k = 0; k < 40; k++) begin
            do_instr(mk(7'($urandom_range(0, 15)), 3'($urandom), 3'($urandom),
                        3'($urandom), 16'($urandom)), $urandom_range(0, 2));
        end

        reset_n = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = mk(7'd7, 3'd3, 3'd0, 3'd0, 16'h1234);
        #1;
        chk("rstf_req", 32'(imem_req), 32'd0);
        chk("rstf_retire", 32'(retire), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        imem_ack = 1'b0;
        model_reset();
        #1;
        chk("rstf_req_rise", 32'(imem_req), 32'd1);
        chk("rstf_addr", imem_addr, 32'd0);
        do_instr(mk(7'd0, 3'd0, 3'd3, 3'd3, 16'd0), 0);
        chk("dropped_word", last_a, 32'd0);

        for (int k = 0; k < 10; k++) begin
            do_instr(mk(7'($urandom_range(0, 15)), 3'($urandom), 3'($urandom),
                        3'($urandom), 16'($urandom)), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
